// File: rtl/stopwatch_watch_ctrl.sv
// Control unit for the combined stopwatch/watch design.
// Turns debounced button pulses, held levels and the mode/edit switches into
// stopwatch run/clear controls and watch field-edit commands (field select,
// up/down pulses with auto-repeat, edit timeout, LED blink).
module stopwatch_watch_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int EDIT_TIMEOUT_MS = 10_000,
  parameter int BLINK_HALF_MS   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_stopwatch,
  input  logic       i_edit,
  input  logic       i_btn_u,
  input  logic       i_btn_d,
  input  logic       i_btn_r,
  input  logic       i_btn_l,
  input  logic       i_hold_u,
  input  logic       i_hold_d,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic [1:0] o_field,
  output logic [1:0] o_edit_sign,
  output logic       o_editing,
  output logic [3:0] o_led
);

  localparam logic [1:0] ST_SW     = 2'd0;
  localparam logic [1:0] ST_WATCH  = 2'd1;
  localparam logic [1:0] ST_EDIT   = 2'd2;
  localparam logic [1:0] ST_LOCK   = 2'd3;

  localparam int DIV  = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(EDIT_TIMEOUT_MS + 1);
  localparam int BW   = $clog2(BLINK_HALF_MS + 1);

  logic [1:0]    state_q, state_d;
  logic          run_q, run_d;
  logic [1:0]    field_q, field_d;
  logic          blocked_q, blocked_d;   // edit stays off until i_edit drops after a timeout
  logic [PW-1:0] pre_q, pre_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          rpt_fast_q, rpt_fast_d; // 0: waiting initial delay, 1: repeating at rate
  logic [1:0]    rpt_dir_q, rpt_dir_d;   // same encoding as o_edit_sign, 00 = not armed
  logic [TW-1:0] to_q, to_d;
  logic [BW-1:0] bl_q, bl_d;
  logic          phase_q, phase_d;
  logic          clear_q, clear_d;
  logic [1:0]    sign_q, sign_d;
  logic          editing_q, editing_d;
  logic [3:0]    led_q, led_d;

  logic          ms_tick;
  logic          btn_ud, up_only, dn_only, any_btn;
  logic          hold_ok, rpt_fire, stay_edit;
  logic [RW-1:0] rpt_inc, rpt_target;
  logic [TW-1:0] to_inc;
  logic [BW-1:0] bl_inc;

  assign ms_tick    = (pre_q == PW'(DIV - 1));
  assign btn_ud     = i_btn_u | i_btn_d;
  assign up_only    = i_btn_u & ~i_btn_d;
  assign dn_only    = i_btn_d & ~i_btn_u;
  assign any_btn    = i_btn_u | i_btn_d | i_btn_r | i_btn_l;
  assign rpt_inc    = rpt_q + RW'(1);
  assign rpt_target = rpt_fast_q ? RW'(REPEAT_RATE_MS) : RW'(REPEAT_DELAY_MS);
  assign to_inc     = to_q + TW'(1);
  assign bl_inc     = bl_q + BW'(1);
  assign hold_ok    = (rpt_dir_q == 2'b01 && i_hold_u && !i_hold_d) ||
                      (rpt_dir_q == 2'b10 && i_hold_d && !i_hold_u);

  // Next-state logic: view switch first, then edit/timeout, then buttons.
  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    field_d    = field_q;
    blocked_d  = blocked_q;
    pre_d      = ms_tick ? '0 : pre_q + PW'(1);
    rpt_d      = rpt_q;
    rpt_fast_d = rpt_fast_q;
    rpt_dir_d  = rpt_dir_q;
    to_d       = to_q;
    bl_d       = bl_q;
    phase_d    = phase_q;
    clear_d    = 1'b0;
    sign_d     = 2'b00;
    rpt_fire   = 1'b0;

    if (!i_edit) blocked_d = 1'b0;

    if (i_stopwatch) begin
      state_d = ST_SW;
      if (!btn_ud) begin
        if (i_btn_r) run_d = ~run_q;
        if (i_btn_l && !run_q) clear_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_EDIT: begin
          if (!i_edit) begin
            state_d = ST_WATCH;
          end else if (ms_tick && to_inc == TW'(EDIT_TIMEOUT_MS)) begin
            state_d   = ST_LOCK;
            blocked_d = 1'b1;
          end
        end
        ST_LOCK: if (!i_edit) state_d = ST_WATCH;
        default: begin
          if (i_edit && !blocked_q) begin
            state_d = ST_EDIT;
            field_d = 2'd0;
          end else begin
            state_d = ST_WATCH;
          end
        end
      endcase
    end

    stay_edit = (state_q == ST_EDIT) && (state_d == ST_EDIT);

    if (stay_edit) begin
      if (up_only || dn_only) begin
        sign_d     = {dn_only, up_only};
        rpt_dir_d  = {dn_only, up_only};
        rpt_d      = '0;
        rpt_fast_d = 1'b0;
      end else if (btn_ud) begin
        rpt_dir_d  = 2'b00;
        rpt_d      = '0;
        rpt_fast_d = 1'b0;
      end else begin
        if (hold_ok) begin
          if (ms_tick) begin
            if (rpt_inc == rpt_target) begin
              rpt_fire   = 1'b1;
              sign_d     = rpt_dir_q;
              rpt_d      = '0;
              rpt_fast_d = 1'b1;
            end else begin
              rpt_d = rpt_inc;
            end
          end
        end else begin
          rpt_dir_d  = 2'b00;
          rpt_d      = '0;
          rpt_fast_d = 1'b0;
        end
        if (!rpt_fire) begin
          if (i_btn_l && !i_btn_r)      field_d = field_q + 2'd1;
          else if (i_btn_r && !i_btn_l) field_d = field_q - 2'd1;
        end
      end

      if (any_btn || rpt_fire) to_d = '0;
      else if (ms_tick)        to_d = to_inc;

      if (sign_d != 2'b00) begin
        phase_d = 1'b1;
        bl_d    = '0;
      end else if (ms_tick) begin
        if (bl_inc == BW'(BLINK_HALF_MS)) begin
          bl_d    = '0;
          phase_d = ~phase_q;
        end else begin
          bl_d = bl_inc;
        end
      end
    end else begin
      rpt_dir_d  = 2'b00;
      rpt_d      = '0;
      rpt_fast_d = 1'b0;
      to_d       = '0;
      bl_d       = '0;
      phase_d    = 1'b1;
    end

    editing_d = (state_d == ST_EDIT);
    led_d     = (editing_d && phase_d) ? (4'b0001 << field_d) : 4'b0000;
  end

  // State and registered outputs; reset clears everything immediately.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_WATCH;
      run_q      <= 1'b0;
      field_q    <= 2'd0;
      blocked_q  <= 1'b0;
      pre_q      <= '0;
      rpt_q      <= '0;
      rpt_fast_q <= 1'b0;
      rpt_dir_q  <= 2'b00;
      to_q       <= '0;
      bl_q       <= '0;
      phase_q    <= 1'b1;
      clear_q    <= 1'b0;
      sign_q     <= 2'b00;
      editing_q  <= 1'b0;
      led_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      field_q    <= field_d;
      blocked_q  <= blocked_d;
      pre_q      <= pre_d;
      rpt_q      <= rpt_d;
      rpt_fast_q <= rpt_fast_d;
      rpt_dir_q  <= rpt_dir_d;
      to_q       <= to_d;
      bl_q       <= bl_d;
      phase_q    <= phase_d;
      clear_q    <= clear_d;
      sign_q     <= sign_d;
      editing_q  <= editing_d;
      led_q      <= led_d;
    end
  end

  assign o_run_stop  = run_q;
  assign o_clear     = clear_q;
  assign o_field     = field_q;
  assign o_edit_sign = sign_q;
  assign o_editing   = editing_q;
  assign o_led       = led_q;

endmodule
